// File: rtl/mem_stage_lsu.sv
// Memory stage: takes one executed instruction from the ALU stage and
// forwards ALU results to writeback. It runs byte-lane aligned loads and
// stores over a req/gnt/rvalid data-memory bus and emits exactly one
// registered writeback beat per accepted instruction.
//
// Handshakes:
//   ex side : an instruction transfers on a rising edge where ex_valid and
//             ex_ready are both high. ex_ready is high only in IDLE.
//   bus req : dmem_req is held with stable addr/we/wdata/wstrb until the
//             edge where dmem_gnt is high.
//   bus resp: dmem_rvalid is only looked at in RESP, that is, from the cycle
//             after the grant onward.
//   wb side : wb_valid is a one-cycle pulse. There is no backpressure.
module mem_stage_lsu #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [31:0] ex_inst,
   input  logic [31:0] ex_rd_data,
   input  logic [31:0] ex_rs2_data,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic        wb_we,
   output logic [4:0]  wb_rd_addr,
   output logic [31:0] wb_rd_data,
   output logic        lsu_misalign,
   output logic        lsu_fault,
   output logic [1:0]  dbg_state
);

   localparam logic [6:0]  L_OP_LOAD   = 7'b0000011;
   localparam logic [6:0]  L_OP_STORE  = 7'b0100011;
   localparam logic [6:0]  L_OP_OP     = 7'b0110011;
   localparam logic [6:0]  L_OP_OPIMM  = 7'b0010011;
   localparam logic [6:0]  L_OP_LUI    = 7'b0110111;
   localparam logic [6:0]  L_OP_AUIPC  = 7'b0010111;
   localparam logic [6:0]  L_OP_JAL    = 7'b1101111;
   localparam logic [6:0]  L_OP_JALR   = 7'b1100111;
   // The counter equals TIMEOUT-1 on the last cycle a wait is allowed to last.
   localparam logic [15:0] L_CNT_LAST  = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2} state_t;

   state_t      r_state, w_state_nxt;
   logic [15:0] r_cnt;
   logic        r_we;
   logic [31:0] r_addr, r_wdata;
   logic [3:0]  r_wstrb;
   logic [2:0]  r_funct3;
   logic [4:0]  r_rd;
   logic        r_wb_valid, r_wb_we, r_misalign, r_fault;
   logic [4:0]  r_wb_rd;
   logic [31:0] r_wb_data;

   logic        w_wb_valid_nxt, w_wb_we_nxt, w_mis_nxt, w_fault_nxt;
   logic [4:0]  w_wb_rd_nxt;
   logic [31:0] w_wb_data_nxt;

   // Decode of the instruction offered by the execute stage.
   logic [6:0]  w_opc;
   logic [4:0]  w_rd;
   logic [2:0]  w_f3;
   logic        w_is_load, w_is_store, w_is_mem, w_illegal, w_misalign, w_writes_rd;
   logic        w_accept, w_timeout;
   logic [31:0] w_st_wdata, w_ld_shift, w_ld_data;
   logic [3:0]  w_st_wstrb;
   logic        w_unused;

   assign w_opc      = ex_inst[6:0];
   assign w_rd       = ex_inst[11:7];
   assign w_f3       = ex_inst[14:12];
   assign w_unused   = ^ex_inst[31:15];
   assign w_is_load  = (w_opc == L_OP_LOAD);
   assign w_is_store = (w_opc == L_OP_STORE);
   assign w_is_mem   = w_is_load | w_is_store;
   // Loads allow 000/001/010/100/101. Stores allow only 000/001/010.
   assign w_illegal  = (w_is_load  & ((w_f3 == 3'b011) | (w_f3 == 3'b110) | (w_f3 == 3'b111))) |
                       (w_is_store & (w_f3[2] | (w_f3[1:0] == 2'b11)));
   assign w_misalign = w_is_mem & ~w_illegal &
                       (((w_f3[1:0] == 2'b01) & ex_rd_data[0]) |
                        ((w_f3[1:0] == 2'b10) & (ex_rd_data[1:0] != 2'b00)));
   assign w_writes_rd = (w_rd != 5'd0) &
                        ((w_opc == L_OP_OP)  | (w_opc == L_OP_OPIMM) | (w_opc == L_OP_LUI) |
                         (w_opc == L_OP_AUIPC) | (w_opc == L_OP_JAL) | (w_opc == L_OP_JALR));
   assign w_accept   = ex_valid & (r_state == S_IDLE);
   assign w_timeout  = (r_cnt == L_CNT_LAST);

   // Store lane replication and byte enables, computed from the incoming address.
   always_comb begin
      w_st_wdata = ex_rs2_data;
      w_st_wstrb = 4'b1111;
      case (w_f3[1:0])
         2'b00: begin
            w_st_wdata = {4{ex_rs2_data[7:0]}};
            w_st_wstrb = 4'b0001 << ex_rd_data[1:0];
         end
         2'b01: begin
            w_st_wdata = {2{ex_rs2_data[15:0]}};
            w_st_wstrb = 4'b0011 << ex_rd_data[1:0];
         end
         default: ;
      endcase
   end

   // Load formatting: shift the addressed lane down to bit 0, then extend it.
   assign w_ld_shift = dmem_rdata >> {r_addr[1:0], 3'b000};
   always_comb begin
      w_ld_data = dmem_rdata;
      case (r_funct3)
         3'b000:  w_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
         3'b100:  w_ld_data = {24'd0, w_ld_shift[7:0]};
         3'b001:  w_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
         3'b101:  w_ld_data = {16'd0, w_ld_shift[15:0]};
         default: ;
      endcase
   end

   // Next-state logic and the writeback beat to register at the next edge.
   always_comb begin
      w_state_nxt    = r_state;
      w_wb_valid_nxt = 1'b0;
      w_wb_we_nxt    = 1'b0;
      w_wb_rd_nxt    = r_rd;
      w_wb_data_nxt  = 32'd0;
      w_mis_nxt      = 1'b0;
      w_fault_nxt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (ex_valid) begin
               w_wb_rd_nxt = w_rd;
               if (w_is_mem & ~w_illegal & ~w_misalign) begin
                  w_state_nxt = S_REQ;
               end else begin
                  w_wb_valid_nxt = 1'b1;
                  if (w_is_mem) begin
                     w_mis_nxt   = w_misalign;
                     w_fault_nxt = w_illegal;
                  end else begin
                     w_wb_we_nxt   = w_writes_rd;
                     w_wb_data_nxt = ex_rd_data;
                  end
               end
            end
         end
         S_REQ: begin
            if (dmem_gnt) begin
               if (r_we) begin
                  w_state_nxt    = S_IDLE;
                  w_wb_valid_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_RESP;
               end
            end else if (w_timeout) begin
               w_state_nxt    = S_IDLE;
               w_wb_valid_nxt = 1'b1;
               w_fault_nxt    = 1'b1;
            end
         end
         S_RESP: begin
            if (dmem_rvalid) begin
               w_state_nxt    = S_IDLE;
               w_wb_valid_nxt = 1'b1;
               w_wb_we_nxt    = (r_rd != 5'd0);
               w_wb_data_nxt  = w_ld_data;
            end else if (w_timeout) begin
               w_state_nxt    = S_IDLE;
               w_wb_valid_nxt = 1'b1;
               w_fault_nxt    = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register and the wait counter, which restarts on every state change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 16'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_state_nxt != r_state)
            r_cnt <= 16'd0;
         else if (r_state != S_IDLE)
            r_cnt <= r_cnt + 16'd1;
      end
   end

   // Capture the instruction's bus attributes when it is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we     <= 1'b0;
         r_addr   <= 32'd0;
         r_wdata  <= 32'd0;
         r_wstrb  <= 4'd0;
         r_funct3 <= 3'd0;
         r_rd     <= 5'd0;
      end else if (w_accept) begin
         r_we     <= w_is_store;
         r_addr   <= ex_rd_data;
         r_wdata  <= w_st_wdata;
         r_wstrb  <= w_is_store ? w_st_wstrb : 4'd0;
         r_funct3 <= w_f3;
         r_rd     <= w_rd;
      end
   end

   // Writeback register. Valid and status flags fall back to zero every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_valid <= 1'b0;
         r_wb_we    <= 1'b0;
         r_wb_rd    <= 5'd0;
         r_wb_data  <= 32'd0;
         r_misalign <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         r_wb_valid <= w_wb_valid_nxt;
         r_wb_we    <= w_wb_we_nxt;
         r_wb_rd    <= w_wb_valid_nxt ? w_wb_rd_nxt : 5'd0;
         r_wb_data  <= w_wb_data_nxt;
         r_misalign <= w_mis_nxt;
         r_fault    <= w_fault_nxt;
      end
   end

   assign ex_ready     = (r_state == S_IDLE);
   assign dmem_req     = (r_state == S_REQ);
   assign dmem_we      = dmem_req & r_we;
   assign dmem_addr    = dmem_req ? {r_addr[31:2], 2'b00} : 32'd0;
   assign dmem_wdata   = dmem_req ? r_wdata : 32'd0;
   assign dmem_wstrb   = dmem_req ? r_wstrb : 4'd0;
   assign wb_valid     = r_wb_valid;
   assign wb_we        = r_wb_we;
   assign wb_rd_addr   = r_wb_rd;
   assign wb_rd_data   = r_wb_data;
   assign lsu_misalign = r_misalign;
   assign lsu_fault    = r_fault;
   assign dbg_state    = r_state;

endmodule
